// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory, and presents f_instr/f_pcp4 (NOP when invalid) to IF/ID.
// Optional build macro FETCH_PERFCNT_EN adds a saturating imem wait-cycle counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         f_instr,
    output logic [31:0]         f_pcp4,
    output logic                f_valid
`ifdef FETCH_PERFCNT_EN
    ,
    output logic [31:0]         imem_wait_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   ibuf_q, ibuf_d;
    logic [XLEN-1:0]   tgt;
    logic [XLEN-1:0]   pc_inc;
    logic              req;
    logic              unused_rpc_lsb;

    assign tgt            = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc         = pc_q + XLEN'(4);
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ibuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ibuf_q  <= ibuf_d;
        end
    end

    // Next-state and datapath update; redirect always takes priority over en.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ibuf_d  = ibuf_q;
        case (state_q)
            S_FETCH: begin
                if (redirect && imem.imem_ack) begin
                    pc_d   = tgt;
                    addr_d = tgt;
                end else if (redirect) begin
                    // Keep addr_q so the in-flight request can finish cleanly.
                    pc_d    = tgt;
                    state_d = S_DISCARD;
                end else if (imem.imem_ack && en) begin
                    pc_d   = pc_inc;
                    addr_d = pc_inc;
                end else if (imem.imem_ack) begin
                    ibuf_d  = imem.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    addr_d  = tgt;
                    state_d = S_FETCH;
                end else if (en) begin
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    pc_d = tgt;
                end
                if (imem.imem_ack) begin
                    addr_d  = redirect ? tgt : pc_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are combinational so a 0-wait memory sustains one instruction per cycle.
    assign req            = ~rst && (state_q != S_HOLD);
    assign imem.imem_req  = req;
    assign imem.imem_addr = addr_q;
    assign f_valid        = ~rst && ~redirect &&
                            (((state_q == S_FETCH) && imem.imem_ack) || (state_q == S_HOLD));
    assign f_instr        = !f_valid ? '0 : ((state_q == S_HOLD) ? ibuf_q : imem.imem_rdata);
    assign f_pcp4         = f_valid ? pc_inc : '0;

`ifdef FETCH_PERFCNT_EN
    // Saturating count of cycles spent waiting on instruction memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_wait_cnt <= '0;
        end else if (req && !imem.imem_ack && (imem_wait_cnt != '1)) begin
            imem_wait_cnt <= imem_wait_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked
// against a program-order model of which instruction must be presented next.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] f_instr;
    logic [31:0] f_pcp4;
    logic        f_valid;
`ifdef FETCH_PERFCNT_EN
    logic [31:0] wait_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int lat    = 0;
    int wcnt;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .f_instr     (f_instr),
        .f_pcp4      (f_pcp4),
        .f_valid     (f_valid)
`ifdef FETCH_PERFCNT_EN
        ,
        .imem_wait_cnt (wait_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory model: acks once the request has waited 'lat' cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
    assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(f_valid), 32'd0);
        chk("rst_instr", f_instr, 32'd0);
        chk("rst_pcp4", f_pcp4, 32'd0);
        next_cyc();
        rst = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_wait;
    logic [31:0] tmp;
    int          consumed;
    bit          found;

    initial begin
        rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk); #1;

        // 0-wait streaming, one instruction per cycle.
        lat = 0; en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t1_addr", bus.imem_addr, 32'(4 * i));
            chk("t1_valid", 32'(f_valid), 32'd1);
            chk("t1_pcp4", f_pcp4, 32'(4 * i + 4));
            chk("t1_instr", f_instr, mem_word(32'(4 * i)));
            next_cyc();
        end

        // 2-wait memory.
        lat = 2; en = 1'b1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t2_addr_wait", bus.imem_addr, 32'd0);
            chk("t2_valid_wait", 32'(f_valid), 32'd0);
            chk("t2_instr_wait", f_instr, 32'd0);
            next_cyc();
        end
        #2;
        chk("t2_addr", bus.imem_addr, 32'd0);
        chk("t2_instr", f_instr, mem_word(32'd0));
        chk("t2_pcp4", f_pcp4, 32'd4);
        next_cyc();
        for (int i = 0; i < 3; i++) next_cyc();
`ifdef FETCH_PERFCNT_EN
        chk("t6_waitcnt", wait_cnt, 32'd4);
`endif

        // Stall at pc=8 for three cycles.
        lat = 0; en = 1'b1;
        do_reset();
        next_cyc();
        next_cyc();
        en = 1'b0;
        #2;
        chk("t3_instr_f", f_instr, mem_word(32'd8));
        next_cyc();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t3_hold_req", 32'(bus.imem_req), 32'd0);
            chk("t3_hold_instr", f_instr, mem_word(32'd8));
            chk("t3_hold_pcp4", f_pcp4, 32'h0C);
            next_cyc();
        end
        en = 1'b1;
        #2;
        chk("t3_rel_valid", 32'(f_valid), 32'd1);
        next_cyc();
        #2;
        chk("t3_next_addr", bus.imem_addr, 32'h0C);
        next_cyc();

        // Redirect while a 3-wait request is outstanding.
        lat = 3; en = 1'b1;
        do_reset();
        #2;
        chk("t4_addr0", bus.imem_addr, 32'd0);
        next_cyc();
        redirect = 1'b1; redirect_pc = 32'h40;
        #2;
        chk("t4_valid_r", 32'(f_valid), 32'd0);
        next_cyc();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t4_disc_addr", bus.imem_addr, 32'd0);
            chk("t4_disc_req", 32'(bus.imem_req), 32'd1);
            chk("t4_disc_valid", 32'(f_valid), 32'd0);
            next_cyc();
        end
        #2;
        chk("t4_new_addr", bus.imem_addr, 32'h40);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (f_valid) begin found = 1; break; end
            next_cyc();
            #2;
        end
        chk("t4_found", 32'(found), 32'd1);
        chk("t4_pcp4", f_pcp4, 32'h44);
        chk("t4_instr", f_instr, mem_word(32'h40));
        next_cyc();

        // PC wrap while held.
        lat = 0; en = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #2;
        chk("t5_valid_r", 32'(f_valid), 32'd0);
        next_cyc();
        redirect = 1'b0; en = 1'b0;
        #2;
        chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("t5_pcp4_f", f_pcp4, 32'd0);
        next_cyc();
        en = 1'b1;
        #2;
        chk("t5_hold_valid", 32'(f_valid), 32'd1);
        chk("t5_hold_pcp4", f_pcp4, 32'd0);
        chk("t5_hold_instr", f_instr, mem_word(32'hFFFF_FFFC));
        next_cyc();
        #2;
        chk("t5_wrap_addr", bus.imem_addr, 32'd0);
        next_cyc();

        // Reset asserted in the middle of a discard.
        lat = 0; en = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h200;
        next_cyc();
        lat = 3; redirect_pc = 32'h80;
        #2;
        chk("t5b_addr", bus.imem_addr, 32'h200);
        next_cyc();
        redirect = 1'b0;
        #2;
        chk("t5b_disc_addr", bus.imem_addr, 32'h200);
        rst = 1'b1;
        #1;
        chk("t5b_rst_req", 32'(bus.imem_req), 32'd0);
        chk("t5b_rst_addr", bus.imem_addr, 32'd0);
        chk("t5b_rst_valid", 32'(f_valid), 32'd0);
        chk("t5b_rst_instr", f_instr, 32'd0);
        next_cyc();
        rst = 1'b0; lat = 0;
        #2;
        chk("t5b_rel_addr", bus.imem_addr, 32'd0);
        chk("t5b_rel_pcp4", f_pcp4, 32'd4);
        next_cyc();

        // Randomized traffic against the program-order model.
        en = 1'b0; redirect = 1'b0;
        do_reset();
        exp_pc = 32'd0; prev_wait = 1'b0; prev_addr = '0; consumed = 0;
        for (int c = 0; c < 2000; c++) begin
            lat      = int'($urandom_range(0, 3));
            en       = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 9) == 0);
            tmp      = $urandom;
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | (tmp & 32'h7)) : tmp;
            #2;
            if (prev_wait) begin
                chk("r_addr_stable", bus.imem_addr, prev_addr);
                chk("r_req_stable", 32'(bus.imem_req), 32'd1);
            end
            if (redirect) chk("r_redir_kill", 32'(f_valid), 32'd0);
            if (f_valid) begin
                chk("r_pcp4", f_pcp4, exp_pc + 32'd4);
                chk("r_instr", f_instr, mem_word(exp_pc));
            end else begin
                chk("r_nop", f_instr | f_pcp4, 32'd0);
            end
            prev_wait = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (f_valid && en) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            next_cyc();
        end
        chk("r_progress", 32'(consumed > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
